// File: rtl/pipelined_addsub_cc_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation encodings
// and the parameter legality rule used at elaboration.
package pipelined_addsub_cc_pkg;

  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;

  localparam int ADDSUB_MAX_STAGES = 16;

  // WIDTH must split evenly into CHUNK-bit slices, 1..16 slices in total.
  function automatic bit addsub_params_ok(input int width, input int chunk);
    return (chunk > 0) && (width > 0) && ((width % chunk) == 0) &&
           ((width / chunk) <= ADDSUB_MAX_STAGES);
  endfunction

endpackage

// File: rtl/pipelined_addsub_cc_slice.sv
// One CHUNK-bit registered adder slice. Inverts B for subtract, chains carry
// and a running zero bit, and reports the carry into its own MSB so the last
// slice can derive signed overflow.
module addsub_slice
  import pipelined_addsub_cc_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_vld,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic             zin,
  output logic             vld_q,
  output logic [CHUNK-1:0] sum_q,
  output logic             cout_q,
  output logic             cmsb_q,
  output logic             zero_q
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   full_d;
  logic [CHUNK-1:0] sum_d;
  logic             cout_d;
  logic             cmsb_d;
  logic             zero_d;

  // Slice arithmetic: carry into the MSB is recovered as a ^ b ^ sum at that bit.
  always_comb begin
    b_eff = b;
    case (sub)
      ADDSUB_OP_ADD: b_eff = b;
      ADDSUB_OP_SUB: b_eff = ~b;
    endcase
    full_d = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
    sum_d  = full_d[CHUNK-1:0];
    cout_d = full_d[CHUNK];
    cmsb_d = a[CHUNK-1] ^ b_eff[CHUNK-1] ^ sum_d[CHUNK-1];
    zero_d = zin && (sum_d == '0);
  end

  // Valid advances on every enabled cycle; data only loads for a real operation
  // so bubbles never overwrite the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      cmsb_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      vld_q <= in_vld;
      if (in_vld) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        cmsb_q <= cmsb_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: rtl/pipelined_addsub_cc.sv
// Pipelined WIDTH-bit adder/subtractor with condition codes. One CHUNK-bit
// slice per stage; operand slices not yet consumed ride skew registers, and
// finished sum slices ride deskew registers so a whole result emerges at once.
// A single global enable stalls the entire pipe under output backpressure.
module pipelined_addsub_cc
  import pipelined_addsub_cc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSTAGE = WIDTH / CHUNK;

  if (!addsub_params_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("pipelined_addsub_cc: WIDTH must be 1..16 multiples of CHUNK");
  end

  // Index k of a *_d array is what enters stage k; index NSTAGE is the result.
  logic [WIDTH-1:0] a_d   [NSTAGE+1];
  logic [WIDTH-1:0] b_d   [NSTAGE+1];
  logic [WIDTH-1:0] lo_d  [NSTAGE+1];
  logic             sub_d [NSTAGE+1];
  logic             c_d   [NSTAGE+1];
  logic             z_d   [NSTAGE+1];
  logic             v_d   [NSTAGE+1];

  logic [WIDTH-1:0] a_q   [NSTAGE];
  logic [WIDTH-1:0] b_q   [NSTAGE];
  logic [WIDTH-1:0] lo_q  [NSTAGE];
  logic             sub_q [NSTAGE];

  logic             vld_s  [NSTAGE];
  logic [CHUNK-1:0] sum_s  [NSTAGE];
  logic             cout_s [NSTAGE];
  logic             cmsb_s [NSTAGE];
  logic             zero_s [NSTAGE];

  logic en;

  // Stage chaining: merge each finished slice into the deskew vector of its op.
  always_comb begin
    a_d[0]   = in_a;
    b_d[0]   = in_b;
    sub_d[0] = in_sub;
    lo_d[0]  = '0;
    c_d[0]   = in_cin;
    z_d[0]   = 1'b1;
    v_d[0]   = in_valid;
    for (int k = 0; k < NSTAGE; k++) begin
      a_d[k+1]   = a_q[k];
      b_d[k+1]   = b_q[k];
      sub_d[k+1] = sub_q[k];
      lo_d[k+1]  = lo_q[k];
      lo_d[k+1][k*CHUNK +: CHUNK] = sum_s[k];
      c_d[k+1]   = cout_s[k];
      z_d[k+1]   = zero_s[k];
      v_d[k+1]   = vld_s[k];
    end
  end

  // Handshake and result flags, all taken from the final stage registers.
  always_comb begin
    en        = !v_d[NSTAGE] || out_ready;
    in_ready  = en;
    out_valid = v_d[NSTAGE];
    out_sum   = lo_d[NSTAGE];
    out_cout  = c_d[NSTAGE];
    out_neg   = lo_d[NSTAGE][WIDTH-1];
    out_ovf   = cmsb_s[NSTAGE-1] ^ c_d[NSTAGE];
    out_zero  = z_d[NSTAGE];
  end

  // Skew (pending operand slices, op select) and deskew (finished sum slices).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        lo_q[k]  <= '0;
        sub_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (en && v_d[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          lo_q[k]  <= lo_d[k];
          sub_q[k] <= sub_d[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .in_vld (v_d[k]),
      .a      (a_d[k][k*CHUNK +: CHUNK]),
      .b      (b_d[k][k*CHUNK +: CHUNK]),
      .sub    (sub_d[k]),
      .cin    (c_d[k]),
      .zin    (z_d[k]),
      .vld_q  (vld_s[k]),
      .sum_q  (sum_s[k]),
      .cout_q (cout_s[k]),
      .cmsb_q (cmsb_s[k]),
      .zero_q (zero_s[k])
    );
  end

endmodule
